// File: rtl/bus_arb_defs.sv
// Shared definitions for the two-requester bus arbiter: state encodings, mux
// select polarity and the default hold limit.
package bus_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_e;

    localparam logic SEL_REQ0 = 1'b1;
    localparam logic SEL_REQ1 = 1'b0;

    localparam int unsigned DEFAULT_MAX_HOLD = 16;

endpackage

// File: rtl/bit8_2to1mux.sv
// 8-bit two-input multiplexer; select=1 passes in0, select=0 passes in1.
module bit8_2to1mux (
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic       select,
    output logic [7:0] out
);

    assign out = select ? in0 : in1;

endmodule

// File: rtl/bus_arbiter2.sv
// Two-requester round-robin bus arbiter with registered grants and mux select.
// Optional HOLD_LIMIT_EN macro adds a hold counter forcing hand-over after MAX_HOLD cycles.
module bus_arbiter2
    import bus_arb_defs::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_HOLD  = DEFAULT_MAX_HOLD,
    parameter logic        PRIO_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             done0,
    input  logic             done1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid
);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic             hand_over;
    logic [WIDTH-1:0] mux_out;

    // A limit below 2 cannot express a forced hand-over; the block marks such builds.
    if (MAX_HOLD < 2) begin : g_max_hold_illegal
    end

`ifdef HOLD_LIMIT_EN
    localparam int unsigned HoldW   = $clog2(MAX_HOLD);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             hold_hit;

    assign hold_hit  = (hold_q == HoldMax);
    assign hand_over = hold_hit && ((state_q == ST_GRANT0) ? req1 : req0);

    // Count only while the same grant persists; any entry or IDLE restarts from zero.
    always_comb begin
        hold_d = '0;
        if ((state_d == state_q) && (state_q != ST_IDLE)) begin
            hold_d = hold_hit ? hold_q : hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hand_over = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 && (!req1 || last_q)) begin
                    state_d = ST_GRANT0;
                    sel_d   = SEL_REQ0;
                end else if (req1) begin
                    state_d = ST_GRANT1;
                    sel_d   = SEL_REQ1;
                end
            end
            ST_GRANT0: begin
                if (done0 || !req0 || hand_over) begin
                    last_d = 1'b0;
                    if (req1) begin
                        state_d = ST_GRANT1;
                        sel_d   = SEL_REQ1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GRANT1: begin
                if (done1 || !req1 || hand_over) begin
                    last_d = 1'b1;
                    if (req0) begin
                        state_d = ST_GRANT0;
                        sel_d   = SEL_REQ0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= ~PRIO_INIT;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    bit8_2to1mux u_mux (
        .in0    (data0),
        .in1    (data1),
        .select (sel_q),
        .out    (mux_out)
    );

    assign gnt0      = (state_q == ST_GRANT0);
    assign gnt1      = (state_q == ST_GRANT1);
    assign sel       = sel_q;
    assign bus_valid = gnt0 | gnt1;
    assign bus_out   = bus_valid ? mux_out : '0;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Scoreboard bench for bus_arbiter2: the driver queues hand-computed expected outputs,
// a negedge monitor pops and compares them. Honours HOLD_LIMIT_EN when defined.
module tb_bus_arbiter2;

    localparam logic [7:0] D0 = 8'hA5;
    localparam logic [7:0] D1 = 8'h3C;
`ifdef HOLD_LIMIT_EN
    localparam bit HL = 1'b1;
`else
    localparam bit HL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, done0 = 1'b0, done1 = 1'b0;
    logic [7:0] data0 = D0, data1 = D1;
    logic       gnt0, gnt1, sel, bus_valid;
    logic [7:0] bus_out;

    typedef struct {
        string      name;
        logic       g0;
        logic       g1;
        logic       sel;
        logic [7:0] out;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    bit   stall = 1'b0;
    bit   stall_seen = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter2 #(
        .WIDTH     (8),
        .MAX_HOLD  (4),
        .PRIO_INIT (1'b0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .done0     (done0),
        .done1     (done1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .bus_out   (bus_out),
        .bus_valid (bus_valid)
    );

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input string nm, input logic rn, input logic r0, input logic r1,
                       input logic dn0, input logic dn1, input logic [7:0] d0,
                       input logic [7:0] d1, input logic eg0, input logic eg1,
                       input logic esel, input logic [7:0] eout);
        exp_t e;
        @(negedge clk);
        #1;
        reset_n = rn;
        req0    = r0;
        req1    = r1;
        done0   = dn0;
        done1   = dn1;
        data0   = d0;
        data1   = d1;
        e.name  = nm;
        e.g0    = eg0;
        e.g1    = eg1;
        e.sel   = esel;
        e.out   = eout;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if ({gnt0, gnt1, sel, bus_out, bus_valid} !==
                {cur.g0, cur.g1, cur.sel, cur.out, cur.g0 | cur.g1}) begin
                errors++;
                $display("FAIL %s: got gnt0=%b gnt1=%b sel=%b bus_out=%h bus_valid=%b, expected gnt0=%b gnt1=%b sel=%b bus_out=%h bus_valid=%b",
                         cur.name, gnt0, gnt1, sel, bus_out, bus_valid,
                         cur.g0, cur.g1, cur.sel, cur.out, cur.g0 | cur.g1);
            end
        end else if (stall && !stall_seen) begin
            stall_seen = 1'b1;
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
    end

    initial begin
        // Reset with both requests asserted
        cyc("rst0",       0, 1, 1, 0, 0, D0, D1, 0, 0, 0, 8'h00);
        cyc("rst1",       0, 1, 1, 0, 0, D0, D1, 0, 0, 0, 8'h00);
        // Tie after reset goes to requester 0, then strict alternation
        cyc("tie_g0",     1, 1, 1, 0, 0, D0, D1, 1, 0, 1, D0);
        cyc("r1_g1",      1, 1, 1, 1, 0, D0, D1, 0, 1, 0, D1);
        cyc("r1_hold",    1, 1, 1, 0, 0, D0, D1, 0, 1, 0, D1);
        cyc("r2_g0",      1, 1, 1, 0, 1, D0, D1, 1, 0, 1, D0);
        cyc("r3_g1",      1, 1, 1, 1, 0, D0, D1, 0, 1, 0, D1);
        cyc("r4_g0",      1, 1, 1, 0, 1, D0, D1, 1, 0, 1, D0);
        cyc("r5_g1",      1, 1, 1, 1, 0, D0, D1, 0, 1, 0, D1);
        // Non-owner done is ignored; dropping requests returns to IDLE
        cyc("nonowner",   1, 1, 1, 1, 0, D0, D1, 0, 1, 0, D1);
        cyc("drop_all",   1, 0, 0, 0, 0, D0, D1, 0, 0, 0, 8'h00);
        cyc("idle_done",  1, 0, 0, 1, 1, D0, D1, 0, 0, 0, 8'h00);
        // Single requester 0, release by done while still requesting
        cyc("single_g0",  1, 1, 0, 0, 0, D0, D1, 1, 0, 1, D0);
        cyc("done_rereq", 1, 1, 0, 1, 0, D0, D1, 0, 0, 1, 8'h00);
        cyc("rearb_g0",   1, 1, 0, 0, 0, D0, D1, 1, 0, 1, D0);
        cyc("req_drop",   1, 0, 0, 0, 0, D0, D1, 0, 0, 1, 8'h00);
        // Single requester 1; bus_out follows data combinationally
        cyc("single_g1",  1, 0, 1, 0, 0, D0, D1, 0, 1, 0, D1);
        cyc("data_follow",1, 0, 1, 0, 0, D0, 8'h5A, 0, 1, 0, 8'h5A);
        cyc("g1_done",    1, 0, 1, 0, 1, D0, D1, 0, 0, 0, 8'h00);
        cyc("g1_rereq",   1, 0, 1, 0, 0, D0, D1, 0, 1, 0, D1);
        cyc("idle2",      1, 0, 0, 0, 0, D0, D1, 0, 0, 0, 8'h00);
        // Hold limit with competing requester raised in the first grant cycle
        cyc("hl_a",       1, 1, 0, 0, 0, D0, D1, 1, 0, 1, D0);
        for (int i = 0; i < 3; i++) begin
            cyc("hl_hold",    1, 1, 1, 0, 0, D0, D1, 1, 0, 1, D0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc("hl_after",   1, 1, 1, 0, 0, D0, D1, !HL, HL, !HL, HL ? D1 : D0);
        end
        cyc("hl_idle",    1, 0, 0, 0, 0, D0, D1, 0, 0, !HL, 8'h00);
        // Without a competitor the grant is never cut short
        for (int i = 0; i < 6; i++) begin
            cyc("hl_alone",   1, 1, 0, 0, 0, D0, D1, 1, 0, 1, D0);
        end
        cyc("hl_alone_end", 1, 0, 0, 0, 0, D0, D1, 0, 0, 1, 8'h00);
        // Reset mid-grant, then tie must go to requester 0 again
        cyc("t6_g0",      1, 1, 0, 0, 0, D0, D1, 1, 0, 1, D0);
        cyc("t6_rst",     0, 1, 1, 0, 0, D0, D1, 0, 0, 0, 8'h00);
        cyc("t6_tie",     1, 1, 1, 0, 0, D0, D1, 1, 0, 1, D0);
        cyc("t6_hand",    1, 1, 1, 1, 0, D0, D1, 0, 1, 0, D1);
        cyc("t6_end",     1, 0, 0, 0, 0, D0, D1, 0, 0, 0, 8'h00);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            stall = 1'b1;
            exp_q.delete();
            @(negedge clk);
            #1;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter2.md
Name: bus_arbiter2

Overview:
- Two-requester round-robin arbiter that shares one WIDTH-bit bus.
- It drives the select input of a bit8_2to1mux datapath and owns the registered grant handshake, the fairness pointer and the hold-limit counter.
- It sits between two producer units (requester 0 on in0, requester 1 on in1) and the shared bus consumer.

Parameters:
- WIDTH, 8, data width of each requester and of bus_out. Must be 8 when the bit8_2to1mux instance is used.
- MAX_HOLD, 16, maximum consecutive grant cycles before forced hand-over (HOLD_LIMIT_EN only). Must be >= 2.
- PRIO_INIT, 0, requester that wins the first simultaneous request after reset.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, synchronous active-low reset. One clock; reset sampled only on the rising edge of clk.
- req0, input, 1, requester 0 wants the bus; held until granted and finished.
- req1, input, 1, requester 1 wants the bus.
- done0, input, 1, requester 0 releases the bus (1-cycle pulse); ignored unless gnt0=1.
- done1, input, 1, requester 1 releases the bus; ignored unless gnt1=1.
- data0, input, WIDTH, requester 0 payload.
- data1, input, WIDTH, requester 1 payload.
- gnt0, output, 1, requester 0 owns the bus (registered).
- gnt1, output, 1, requester 1 owns the bus (registered).
- sel, output, 1, mux select: 1 passes data0, 0 passes data1 (registered).
- bus_out, output, WIDTH, selected payload, combinational through the mux, forced to 0 when bus_valid=0.
- bus_valid, output, 1, equals gnt0|gnt1.

Behaviour:
- States: IDLE, GRANT0, GRANT1. Encoding is one-hot or binary (implementer's choice). gnt0=(state==GRANT0), gnt1=(state==GRANT1). gnt0 and gnt1 are never both 1.
- Reset (reset_n=0 at a clk edge): state=IDLE, gnt0=gnt1=0, sel=0, bus_valid=0, bus_out=0, hold_cnt=0, last=~PRIO_INIT. Reset mid-grant drops the grant at that same edge; no done is required.
- Latency: a request seen in IDLE at edge N gives its gnt high after edge N (visible in cycle N+1). sel is updated on the same edge as gnt.
- IDLE:
  - req0 only -> GRANT0.
  - req1 only -> GRANT1.
  - both -> grant the requester != last.
  - none -> stay in IDLE.
- GRANTx, release condition is donex=1 OR reqx=0. On release:
  - other requester's req=1 -> go directly to GRANTother, with no IDLE bubble.
  - otherwise -> IDLE.
  - last <= x.
- GRANTx, no release: stay in GRANTx; hold_cnt increments and saturates at MAX_HOLD-1.
- hold_cnt clears to 0 on every grant entry and in IDLE.
- sel holds its last value in IDLE (bus_out is gated by bus_valid, not sel). Decided: sel=1 in GRANT0, sel=0 in GRANT1.
- done and req deassert in the same cycle count as a single release.
- A done pulse from the non-owner has no effect. A done pulse in IDLE has no effect.
- Simultaneous release by the owner and a new request by the same owner: release wins. The owner re-requests and is re-arbitrated against the other requester.

Optional Feature:
- Macro: HOLD_LIMIT_EN.
- Defined:
  - In GRANTx with hold_cnt==MAX_HOLD-1 and other req=1 -> forced hand-over to GRANTother next edge; last <= x.
  - If the other requester is idle, the grant continues and hold_cnt stays saturated.
- Undefined:
  - hold_cnt logic is absent. A grant lasts until release, unbounded.

Decomposition:
- Shared package/header bus_arb_defs holds:
  - state encodings ST_IDLE, ST_GRANT0, ST_GRANT1.
  - SEL_REQ0=1 and SEL_REQ1=0 (mux polarity).
  - Default MAX_HOLD.
- One natural sub-module: the existing bit8_2to1mux, instantiated for the datapath (out=bus_out pre-gating, select=sel, in0=data0, in1=data1).
- The FSM and counter stay in bus_arbiter2.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with req0=req1=1 -> gnt0=gnt1=0, bus_valid=0, bus_out=0x00 throughout.
2. Single request: req0=1, data0=0xA5 -> after one edge gnt0=1, sel=1, bus_out=0xA5. Pulse done0 -> IDLE next edge, bus_out=0x00.
3. Tie and fairness: req0=req1=1 from reset with PRIO_INIT=0 -> GRANT0. done0 -> GRANT1 on the next edge with no bubble, sel=0, bus_out=data1=0x3C. Repeat 4 rounds -> grants strictly alternate.
4. Non-owner done: in GRANT1, pulse done0 -> no state change. Drop req1 -> IDLE.
5. HOLD_LIMIT_EN, MAX_HOLD=4: req0 held, req1 raised in the grant's first cycle -> gnt0 high exactly 4 cycles, then gnt1. Same test with req1=0 -> gnt0 stays high beyond 4 cycles.
6. Reset mid-grant: in GRANT0, reset_n=0 for one edge -> gnt0=0, state IDLE. After reset_n=1 with both requests pending -> GRANT0 (last reset to ~PRIO_INIT).
